// File: rtl/ram_sdp_be_init.sv
// Simple dual-port RAM: byte-enable write port, synchronous read port with valid strobe,
// and a power-up sequencer that fills every word with INIT_VAL before accepting traffic.
//
// state | meaning
// INIT  | sweeping init_ptr over the array writing INIT_VAL; port requests ignored
// READY | array initialised; reads and writes accepted
module ram_sdp_be_init #(
  parameter int unsigned      WIDTH    = 32,
  parameter int unsigned      DEPTH    = 16,
  parameter int unsigned      ADDR     = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter bit               OUT_REG  = 1'b0,
  parameter bit               RDW_NEW  = 1'b0,
  parameter logic [WIDTH-1:0] INIT_VAL = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_en,
  input  logic [ADDR-1:0]    wr_addr,
  input  logic [WIDTH-1:0]   wr_data,
  input  logic [WIDTH/8-1:0] wr_be,
  input  logic               rd_en,
  input  logic [ADDR-1:0]    rd_addr,
  output logic [WIDTH-1:0]   rd_data,
  output logic               rd_valid,
  output logic               ready,
  output logic               addr_err
);

  localparam int unsigned     NB        = WIDTH / 8;
  localparam logic [ADDR:0]   DEPTH_W   = (ADDR + 1)'(DEPTH);
  localparam logic [ADDR-1:0] LAST_ADDR = ADDR'(DEPTH - 1);

  typedef enum logic [0:0] {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [ADDR-1:0] init_ptr_q, init_ptr_d;
  logic            init_we;

  logic [WIDTH-1:0] mem [DEPTH];

  logic             wr_in_range, rd_in_range;
  logic             wr_fire, rd_fire, err_hit;
  logic [WIDTH-1:0] wr_merged;
  logic [WIDTH-1:0] rd_word;
  logic [WIDTH-1:0] rd_data_q;
  logic             rd_valid_q;
  logic             addr_err_q;

  // ---------------------------------------------------------------- sequencer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_INIT;
      init_ptr_q <= '0;
    end else begin
      state_q    <= state_d;
      init_ptr_q <= init_ptr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    init_ptr_d = init_ptr_q;
    init_we    = 1'b0;
    case (state_q)
      ST_INIT: begin
        init_we = 1'b1;
        if (init_ptr_q == LAST_ADDR) begin
          state_d    = ST_READY;
          init_ptr_d = '0;
        end else begin
          init_ptr_d = init_ptr_q + 1'b1;
        end
      end
      ST_READY: begin
        state_d = ST_READY;
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  assign ready = (state_q == ST_READY);

  // ---------------------------------------------------------------- request qualification
  // Addresses past DEPTH only exist when DEPTH is not a power of two.
  assign wr_in_range = ({1'b0, wr_addr} < DEPTH_W);
  assign rd_in_range = ({1'b0, rd_addr} < DEPTH_W);

  assign wr_fire = ready & wr_en & wr_in_range;
  assign rd_fire = ready & rd_en & rd_in_range;
  assign err_hit = ready & ((wr_en & ~wr_in_range) | (rd_en & ~rd_in_range));

  // ---------------------------------------------------------------- storage
  always_comb begin
    wr_merged = mem[wr_addr];
    for (int i = 0; i < NB; i++) begin
      if (wr_be[i]) wr_merged[8*i +: 8] = wr_data[8*i +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (init_we) begin
      mem[init_ptr_q] <= INIT_VAL;
    end else if (wr_fire) begin
      mem[wr_addr] <= wr_merged;
    end
  end

  // Same-address bypass returns the post-write word; otherwise the stored (old) word.
  always_comb begin
    rd_word = mem[rd_addr];
    if (RDW_NEW && wr_fire && (wr_addr == rd_addr)) begin
      rd_word = wr_merged;
    end
  end

  // ---------------------------------------------------------------- read pipeline
  generate
    if (OUT_REG) begin : g_out_reg
      logic             s1_valid;
      logic [WIDTH-1:0] s1_data;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          s1_valid   <= 1'b0;
          s1_data    <= '0;
          rd_valid_q <= 1'b0;
          rd_data_q  <= '0;
        end else begin
          s1_valid   <= rd_fire;
          rd_valid_q <= s1_valid;
          if (rd_fire)  s1_data   <= rd_word;
          if (s1_valid) rd_data_q <= s1_data;
        end
      end
    end else begin : g_no_out_reg
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rd_valid_q <= 1'b0;
          rd_data_q  <= '0;
        end else begin
          rd_valid_q <= rd_fire;
          if (rd_fire) rd_data_q <= rd_word;
        end
      end
    end
  endgenerate

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;

  // ---------------------------------------------------------------- sticky address error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_err_q <= 1'b0;
    end else if (err_hit) begin
      addr_err_q <= 1'b1;
    end
  end

  assign addr_err = addr_err_q;

endmodule

// File: tb/tb_ram_sdp_be_init.sv
// Directed bench for ram_sdp_be_init: three instances (latency 1 / old-data, latency 2 /
// new-data, DEPTH=12) share stimulus; expected values are hand-computed.
module tb_ram_sdp_be_init;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_be;
  logic        rd_en;
  logic [3:0]  rd_addr;
  logic        en2;

  logic [31:0] rd_data0, rd_data1, rd_data2;
  logic        rd_valid0, rd_valid1, rd_valid2;
  logic        ready0, ready1, ready2;
  logic        addr_err0, addr_err1, addr_err2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ram_sdp_be_init #(.WIDTH(32), .DEPTH(16), .OUT_REG(1'b0), .RDW_NEW(1'b0),
                    .INIT_VAL(32'hA5A5A5A5)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data0), .rd_valid(rd_valid0), .ready(ready0), .addr_err(addr_err0));

  ram_sdp_be_init #(.WIDTH(32), .DEPTH(16), .OUT_REG(1'b1), .RDW_NEW(1'b1),
                    .INIT_VAL(32'hA5A5A5A5)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data1), .rd_valid(rd_valid1), .ready(ready1), .addr_err(addr_err1));

  ram_sdp_be_init #(.WIDTH(32), .DEPTH(12), .OUT_REG(1'b0), .RDW_NEW(1'b0),
                    .INIT_VAL(32'h0F0F0F0F)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en & en2), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .rd_en(rd_en & en2), .rd_addr(rd_addr),
    .rd_data(rd_data2), .rd_valid(rd_valid2), .ready(ready2), .addr_err(addr_err2));

  typedef struct packed {
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_be;
    logic        rd_en;
    logic [3:0]  rd_addr;
    logic        v0;
    logic [31:0] d0;
    logic        v1;
    logic [31:0] d1;
  } vec_t;

  vec_t vecs [16];

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    wr_en   = 1'b0;
    wr_addr = 4'd0;
    wr_data = 32'h0;
    wr_be   = 4'h0;
    rd_en   = 1'b0;
    rd_addr = 4'd0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    en2   = 1'b1;
    set_idle();
    repeat (3) tick();

    chk1 ("rst_ready0",    ready0,    1'b0);
    chk1 ("rst_ready1",    ready1,    1'b0);
    chk1 ("rst_ready2",    ready2,    1'b0);
    chk1 ("rst_valid0",    rd_valid0, 1'b0);
    chk1 ("rst_valid1",    rd_valid1, 1'b0);
    chk32("rst_data0",     rd_data0,  32'h0);
    chk32("rst_data1",     rd_data1,  32'h0);
    chk1 ("rst_addr_err1", addr_err1, 1'b0);
    chk1 ("rst_addr_err2", addr_err2, 1'b0);

    // INIT sweep; requests during the first 10 edges must be ignored
    wr_en = 1'b1; wr_addr = 4'd13; wr_data = 32'h0; wr_be = 4'hF;
    rd_en = 1'b1; rd_addr = 4'd13;
    rst_n = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      if (k == 11) set_idle();
      tick();
      chk1($sformatf("init_ready0[%0d]", k), ready0, k >= 16);
      chk1($sformatf("init_ready1[%0d]", k), ready1, k >= 16);
      chk1($sformatf("init_ready2[%0d]", k), ready2, k >= 12);
      chk1($sformatf("init_valid0[%0d]", k), rd_valid0, 1'b0);
      chk1($sformatf("init_valid1[%0d]", k), rd_valid1, 1'b0);
      chk1($sformatf("init_valid2[%0d]", k), rd_valid2, 1'b0);
      chk1($sformatf("init_err2[%0d]", k), addr_err2, 1'b0);
    end
    en2 = 1'b0;

    // Read back every word: INIT_VAL everywhere, including addr 13 written during INIT
    for (int a = 0; a <= 16; a++) begin
      rd_en   = (a < 16);
      rd_addr = a[3:0];
      tick();
      chk1($sformatf("rb_valid0[%0d]", a), rd_valid0, a < 16);
      if (a < 16) chk32($sformatf("rb_data0[%0d]", a), rd_data0, 32'hA5A5A5A5);
      chk1($sformatf("rb_valid1[%0d]", a), rd_valid1, a >= 1);
      if (a >= 1) chk32($sformatf("rb_data1[%0d]", a - 1), rd_data1, 32'hA5A5A5A5);
    end
    set_idle();

    // Byte enables, read-during-write, independent ports, wr_be=0 no-op
    vecs[0]  = '{1'b1, 4'd3, 32'h11223344, 4'hF, 1'b0, 4'd0, 1'b0, 32'h0, 1'b0, 32'h0};
    vecs[1]  = '{1'b1, 4'd3, 32'hFFFFFFFF, 4'h5, 1'b0, 4'd0, 1'b0, 32'h0, 1'b0, 32'h0};
    vecs[2]  = '{1'b0, 4'd0, 32'h0,        4'h0, 1'b1, 4'd3, 1'b1, 32'h11FF33FF, 1'b0, 32'h0};
    vecs[3]  = '{1'b0, 4'd0, 32'h0,        4'h0, 1'b0, 4'd0, 1'b0, 32'h0, 1'b1, 32'h11FF33FF};
    vecs[4]  = '{1'b1, 4'd5, 32'h0,        4'hF, 1'b0, 4'd0, 1'b0, 32'h0, 1'b0, 32'h0};
    vecs[5]  = '{1'b1, 4'd5, 32'hDEADBEEF, 4'hF, 1'b1, 4'd5, 1'b1, 32'h0, 1'b0, 32'h0};
    vecs[6]  = '{1'b0, 4'd0, 32'h0,        4'h0, 1'b1, 4'd5, 1'b1, 32'hDEADBEEF, 1'b1, 32'hDEADBEEF};
    vecs[7]  = '{1'b0, 4'd0, 32'h0,        4'h0, 1'b0, 4'd0, 1'b0, 32'h0, 1'b1, 32'hDEADBEEF};
    vecs[8]  = '{1'b1, 4'd5, 32'h0,        4'h3, 1'b1, 4'd5, 1'b1, 32'hDEADBEEF, 1'b0, 32'h0};
    vecs[9]  = '{1'b0, 4'd0, 32'h0,        4'h0, 1'b0, 4'd0, 1'b0, 32'h0, 1'b1, 32'hDEAD0000};
    vecs[10] = '{1'b1, 4'd6, 32'h12345678, 4'hF, 1'b1, 4'd3, 1'b1, 32'h11FF33FF, 1'b0, 32'h0};
    vecs[11] = '{1'b0, 4'd0, 32'h0,        4'h0, 1'b1, 4'd6, 1'b1, 32'h12345678, 1'b1, 32'h11FF33FF};
    vecs[12] = '{1'b1, 4'd6, 32'hFFFFFFFF, 4'h0, 1'b0, 4'd0, 1'b0, 32'h0, 1'b1, 32'h12345678};
    vecs[13] = '{1'b0, 4'd0, 32'h0,        4'h0, 1'b1, 4'd6, 1'b1, 32'h12345678, 1'b0, 32'h0};
    vecs[14] = '{1'b0, 4'd0, 32'h0,        4'h0, 1'b0, 4'd0, 1'b0, 32'h0, 1'b1, 32'h12345678};
    vecs[15] = '{1'b0, 4'd0, 32'h0,        4'h0, 1'b0, 4'd0, 1'b0, 32'h0, 1'b0, 32'h0};

    for (int i = 0; i < 16; i++) begin
      wr_en   = vecs[i].wr_en;
      wr_addr = vecs[i].wr_addr;
      wr_data = vecs[i].wr_data;
      wr_be   = vecs[i].wr_be;
      rd_en   = vecs[i].rd_en;
      rd_addr = vecs[i].rd_addr;
      tick();
      chk1($sformatf("vec_valid0[%0d]", i), rd_valid0, vecs[i].v0);
      if (vecs[i].v0) chk32($sformatf("vec_data0[%0d]", i), rd_data0, vecs[i].d0);
      chk1($sformatf("vec_valid1[%0d]", i), rd_valid1, vecs[i].v1);
      if (vecs[i].v1) chk32($sformatf("vec_data1[%0d]", i), rd_data1, vecs[i].d1);
    end
    set_idle();

    // Back-to-back reads: load distinct words, then 8 consecutive rd_en
    for (int i = 0; i < 8; i++) begin
      wr_en = 1'b1; wr_addr = i[3:0]; wr_data = 32'h100 + i; wr_be = 4'hF;
      tick();
    end
    set_idle();
    for (int k = 0; k < 10; k++) begin
      rd_en   = (k < 8);
      rd_addr = k[3:0];
      tick();
      chk1($sformatf("b2b_valid0[%0d]", k), rd_valid0, k < 8);
      if (k < 8) chk32($sformatf("b2b_data0[%0d]", k), rd_data0, 32'h100 + k);
      chk1($sformatf("b2b_valid1[%0d]", k), rd_valid1, (k >= 1) && (k <= 8));
      if ((k >= 1) && (k <= 8)) chk32($sformatf("b2b_data1[%0d]", k), rd_data1, 32'h100 + k - 1);
    end
    set_idle();
    chk32("hold_data0", rd_data0, 32'h107);
    chk32("hold_data1", rd_data1, 32'h107);

    // DEPTH=12 out-of-range requests
    en2 = 1'b1;
    chk1("oor_err2_before", addr_err2, 1'b0);
    wr_en = 1'b1; wr_addr = 4'd13; wr_data = 32'h55555555; wr_be = 4'hF;
    tick();
    chk1("oor_wr_err2",   addr_err2, 1'b1);
    chk1("oor_wr_valid2", rd_valid2, 1'b0);
    chk1("oor_err0",      addr_err0, 1'b0);
    set_idle();
    rd_en = 1'b1; rd_addr = 4'd13;
    tick();
    chk1("oor_rd_valid2", rd_valid2, 1'b0);
    chk1("oor_rd_err2",   addr_err2, 1'b1);
    rd_addr = 4'd11;
    tick();
    chk1 ("last_valid2", rd_valid2, 1'b1);
    chk32("last_data2",  rd_data2,  32'h0F0F0F0F);
    set_idle();
    tick();
    chk1("sticky_err2",  addr_err2, 1'b1);
    chk1("sticky_valid2", rd_valid2, 1'b0);

    // Reset with a read in flight in the two-stage pipeline
    rd_en = 1'b1; rd_addr = 4'd3;
    tick();
    chk1 ("flight_valid0", rd_valid0, 1'b1);
    chk32("flight_data0",  rd_data0,  32'h103);
    chk1 ("flight_valid1", rd_valid1, 1'b0);
    set_idle();
    #1 rst_n = 1'b0;
    #1;
    chk1 ("arst_valid0", rd_valid0, 1'b0);
    chk1 ("arst_valid1", rd_valid1, 1'b0);
    chk32("arst_data0",  rd_data0,  32'h0);
    chk32("arst_data1",  rd_data1,  32'h0);
    chk32("arst_data2",  rd_data2,  32'h0);
    chk1 ("arst_ready0", ready0,    1'b0);
    chk1 ("arst_err2",   addr_err2, 1'b0);
    tick();
    rst_n = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      tick();
      chk1($sformatf("discard_valid1[%0d]", k), rd_valid1, 1'b0);
      chk1($sformatf("partial_ready0[%0d]", k), ready0, 1'b0);
    end

    // Reset again at init_ptr=7: INIT must restart and take the full DEPTH cycles
    rst_n = 1'b0;
    #1;
    chk1("mid_init_ready0", ready0, 1'b0);
    tick();
    rst_n = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      tick();
      chk1($sformatf("reinit_ready0[%0d]", k), ready0, k >= 16);
      chk1($sformatf("reinit_ready1[%0d]", k), ready1, k >= 16);
      chk1($sformatf("reinit_ready2[%0d]", k), ready2, k >= 12);
      chk1($sformatf("reinit_valid1[%0d]", k), rd_valid1, 1'b0);
    end
    en2 = 1'b0;
    chk1("reinit_err1", addr_err1, 1'b0);

    rd_en = 1'b1; rd_addr = 4'd3;
    tick();
    chk1 ("reinit_rd_valid0", rd_valid0, 1'b1);
    chk32("reinit_rd_data0",  rd_data0,  32'hA5A5A5A5);
    set_idle();
    tick();
    chk1 ("reinit_rd_valid1", rd_valid1, 1'b1);
    chk32("reinit_rd_data1",  rd_data1,  32'hA5A5A5A5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
